// File: rtl/protection_sequencer.sv
// Protection sequencer: debounces comparator faults, gates PWM, and runs a
// hiccup retry sequence that ends in a latched lockout after RETRY_MAX restarts.
//
// state   | meaning
// IDLE    | converter disabled, PWM off, retry count cleared while i_en is low
// RUN     | PWM enabled, fault channels debounced
// HICCUP  | timed PWM-off period after a trip, auto-restart at i_hic_len
// LOCKOUT | retries exhausted, PWM off until i_clear
module protection_sequencer #(
    parameter int NCH       = 3,
    parameter int DEB_W     = 8,
    parameter int HIC_W     = 16,
    parameter int RETRY_MAX = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_en,
    input  logic [NCH-1:0]   i_fault_raw,
    input  logic [DEB_W-1:0] i_deb_len,
    input  logic [HIC_W-1:0] i_hic_len,
    input  logic             i_clear,
    output logic             o_pwm_en,
    output logic [NCH-1:0]   o_fault_latched,
    output logic [1:0]       o_state,
    output logic [2:0]       o_retry_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_HICCUP  = 2'd2,
        ST_LOCKOUT = 2'd3
    } state_t;

    localparam logic [2:0] RETRY_LIM = 3'(RETRY_MAX);

    state_t                      state_q, state_d;
    logic [NCH-1:0][DEB_W-1:0]   deb_q, deb_d;
    logic [HIC_W-1:0]            hic_q, hic_d;
    logic [NCH-1:0]              lat_q, lat_d;
    logic [2:0]                  retry_q, retry_d;
    logic                        pwm_q, pwm_d;
    logic [NCH-1:0]              trip;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            deb_q   <= '0;
            hic_q   <= '0;
            lat_q   <= '0;
            retry_q <= '0;
            pwm_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            deb_q   <= deb_d;
            hic_q   <= hic_d;
            lat_q   <= lat_d;
            retry_q <= retry_d;
            pwm_q   <= pwm_d;
        end
    end

    // A tripping channel restarts from zero since the FSM leaves RUN on a trip.
    always_comb begin
        trip  = '0;
        deb_d = '0;
        for (int c = 0; c < NCH; c++) begin
            if (state_q == ST_RUN && i_fault_raw[c]) begin
                if (deb_q[c] == i_deb_len) trip[c] = 1'b1;
                else                       deb_d[c] = deb_q[c] + DEB_W'(1);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        retry_d = retry_q;
        lat_d   = lat_q;
        hic_d   = '0;
        if (i_clear) begin
            lat_d   = '0;
            retry_d = '0;
        end
        case (state_q)
            ST_IDLE: begin
                if (i_en) state_d = ST_RUN;
                else      retry_d = '0;
            end
            ST_RUN: begin
                // A trip overrides both i_en=0 and a same-cycle i_clear.
                if (|trip) begin
                    lat_d = (i_clear ? '0 : lat_q) | trip;
                    if (retry_q == RETRY_LIM) begin
                        state_d = ST_LOCKOUT;
                        retry_d = retry_q;
                    end else begin
                        state_d = ST_HICCUP;
                        retry_d = retry_q + 3'd1;
                    end
                end else if (!i_en) begin
                    state_d = ST_IDLE;
                end
            end
            ST_HICCUP: begin
                if (!i_en) begin
                    state_d = ST_IDLE;
                end else if (hic_q == i_hic_len) begin
                    state_d = ST_RUN;
                end else begin
                    hic_d = (hic_q == '1) ? hic_q : hic_q + HIC_W'(1);
                end
            end
            ST_LOCKOUT: begin
                if (i_clear) state_d = ST_IDLE;
            end
        endcase
        pwm_d = (state_d == ST_RUN);
    end

    assign o_pwm_en        = pwm_q;
    assign o_fault_latched = lat_q;
    assign o_state         = state_q;
    assign o_retry_cnt     = retry_q;

endmodule

// File: tb/tb_protection_sequencer.sv
// Self-checking bench for protection_sequencer: table-driven vectors and
// hand-written sequences, compared through an expected-result queue.
module tb_protection_sequencer;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_HIC  = 2'd2;
    localparam logic [1:0] S_LOCK = 2'd3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic [2:0]  raw;
    logic [7:0]  deb_len;
    logic [15:0] hic_len;
    logic        clr;
    logic        pwm_en;
    logic [2:0]  fault_lat;
    logic [1:0]  state;
    logic [2:0]  retry;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       en;
        logic [2:0] raw;
        logic       clr;
        logic [1:0] st;
        logic [2:0] lat;
        logic [2:0] rt;
    } vec_t;

    typedef struct {
        logic       pwm;
        logic [1:0] st;
        logic [2:0] lat;
        logic [2:0] rt;
    } exp_t;

    vec_t tbl[$];
    exp_t exp_q[$];

    always #5 clk = ~clk;

    protection_sequencer dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_en           (en),
        .i_fault_raw    (raw),
        .i_deb_len      (deb_len),
        .i_hic_len      (hic_len),
        .i_clear        (clr),
        .o_pwm_en       (pwm_en),
        .o_fault_latched(fault_lat),
        .o_state        (state),
        .o_retry_cnt    (retry)
    );

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, req);
        end
    endtask

    task automatic step(input logic e, input logic [2:0] r, input logic c,
                        input logic [1:0] st, input logic [2:0] lat, input logic [2:0] rt);
        exp_t x;
        en  = e;
        raw = r;
        clr = c;
        exp_q.push_back('{(st == S_RUN), st, lat, rt});
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            chk("queue_empty", 16'd1, 16'd0);
        end else begin
            x = exp_q.pop_front();
            chk("state",   {14'd0, state},     {14'd0, x.st});
            chk("pwm_en",  {15'd0, pwm_en},    {15'd0, x.pwm});
            chk("latched", {13'd0, fault_lat}, {13'd0, x.lat});
            chk("retry",   {13'd0, retry},     {13'd0, x.rt});
        end
    endtask

    initial begin
        rst_n   = 1'b0;
        en      = 1'b1;
        raw     = 3'b000;
        clr     = 1'b0;
        deb_len = 8'd4;
        hic_len = 16'd10;

        // Debounce and hiccup timing vectors (deb_len=4, hic_len=10)
        for (int i = 0; i < 4; i++)  tbl.push_back('{1'b1, 3'b010, 1'b0, S_RUN, 3'b000, 3'd0});
        tbl.push_back('{1'b1, 3'b000, 1'b0, S_RUN, 3'b000, 3'd0});
        for (int i = 0; i < 4; i++)  tbl.push_back('{1'b1, 3'b010, 1'b0, S_RUN, 3'b000, 3'd0});
        tbl.push_back('{1'b1, 3'b010, 1'b0, S_HIC, 3'b010, 3'd1});
        for (int i = 0; i < 10; i++) tbl.push_back('{1'b1, 3'b000, 1'b0, S_HIC, 3'b010, 3'd1});
        tbl.push_back('{1'b1, 3'b000, 1'b0, S_RUN, 3'b010, 3'd1});

        repeat (3) @(posedge clk);
        #1;
        chk("rst_state",   {14'd0, state},     16'd0);
        chk("rst_pwm",     {15'd0, pwm_en},    16'd0);
        chk("rst_latched", {13'd0, fault_lat}, 16'd0);
        chk("rst_retry",   {13'd0, retry},     16'd0);
        #3 rst_n = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("post_rst_state",   {14'd0, state},     {14'd0, S_RUN});
        chk("post_rst_pwm",     {15'd0, pwm_en},    16'd1);
        chk("post_rst_latched", {13'd0, fault_lat}, 16'd0);
        chk("post_rst_retry",   {13'd0, retry},     16'd0);

        foreach (tbl[i]) step(tbl[i].en, tbl[i].raw, tbl[i].clr, tbl[i].st, tbl[i].lat, tbl[i].rt);

        // Persistent OVP: three hiccups, then lockout
        deb_len = 8'd0;
        hic_len = 16'd2;
        step(1'b1, 3'b000, 1'b1, S_RUN, 3'b000, 3'd0);
        for (int r = 1; r <= 3; r++) begin
            step(1'b1, 3'b001, 1'b0, S_HIC, 3'b001, 3'(r));
            step(1'b1, 3'b001, 1'b0, S_HIC, 3'b001, 3'(r));
            step(1'b1, 3'b001, 1'b0, S_HIC, 3'b001, 3'(r));
            step(1'b1, 3'b001, 1'b0, S_RUN, 3'b001, 3'(r));
        end
        step(1'b1, 3'b001, 1'b0, S_LOCK, 3'b001, 3'd3);
        step(1'b0, 3'b000, 1'b0, S_LOCK, 3'b001, 3'd3);
        step(1'b1, 3'b000, 1'b0, S_LOCK, 3'b001, 3'd3);
        step(1'b0, 3'b000, 1'b0, S_LOCK, 3'b001, 3'd3);
        step(1'b1, 3'b000, 1'b0, S_LOCK, 3'b001, 3'd3);
        step(1'b1, 3'b000, 1'b1, S_IDLE, 3'b000, 3'd0);
        step(1'b1, 3'b000, 1'b0, S_RUN,  3'b000, 3'd0);

        // Simultaneous OVP and UVP count as a single retry
        step(1'b1, 3'b101, 1'b0, S_HIC, 3'b101, 3'd1);
        step(1'b1, 3'b000, 1'b0, S_HIC, 3'b101, 3'd1);
        step(1'b1, 3'b000, 1'b0, S_HIC, 3'b101, 3'd1);
        step(1'b1, 3'b000, 1'b0, S_RUN, 3'b101, 3'd1);

        // Trip, i_en=0 and i_clear together; then abort hiccup via i_en=0
        step(1'b1, 3'b000, 1'b1, S_RUN,  3'b000, 3'd0);
        step(1'b0, 3'b010, 1'b1, S_HIC,  3'b010, 3'd1);
        step(1'b0, 3'b000, 1'b0, S_IDLE, 3'b010, 3'd1);
        step(1'b0, 3'b000, 1'b0, S_IDLE, 3'b010, 3'd0);

        chk("queue_drained", 16'(exp_q.size()), 16'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
